// File: rtl/soundweb_pkg.sv
// Shared Soundweb framing constants, field layout and decoder state encoding.
// Used by both the packet encoder and the packet decoder.
package soundweb_pkg;

    localparam logic [7:0] STX        = 8'h02;
    localparam logic [7:0] ETX        = 8'h03;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ESC        = 8'h1B;
    localparam logic [7:0] ESC_OFFSET = 8'h80;

    localparam int PAYLOAD_BYTES = 13;
    localparam int FRAME_BYTES   = 14;

    // Position of each unescaped byte within a frame body
    localparam int COMMAND   = 0;
    localparam int ADDRESS_0 = 1;
    localparam int ADDRESS_1 = 2;
    localparam int ADDRESS_2 = 3;
    localparam int ADDRESS_3 = 4;
    localparam int ADDRESS_4 = 5;
    localparam int ADDRESS_5 = 6;
    localparam int SV_0      = 7;
    localparam int SV_1      = 8;
    localparam int DATA_0    = 9;
    localparam int DATA_1    = 10;
    localparam int DATA_2    = 11;
    localparam int DATA_3    = 12;
    localparam int CHECKSUM  = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_ESCAPED = 2'd2
    } state_e;

    function automatic logic is_reserved_byte(input logic [7:0] value);
        case (value)
            STX, ETX, ACK, NAK, ESC: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/soundweb_decoder.sv
// Soundweb receive decoder: frames STX/ETX, removes ESC stuffing, checks the XOR
// checksum and publishes the 13 payload bytes only from fully validated packets.
module soundweb_decoder
    import soundweb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] command,
    output logic [7:0] address_0,
    output logic [7:0] address_1,
    output logic [7:0] address_2,
    output logic [7:0] address_3,
    output logic [7:0] address_4,
    output logic [7:0] address_5,
    output logic [7:0] sv_0,
    output logic [7:0] sv_1,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       packet_valid,
    output logic       checksum_error,
    output logic       framing_error,
    output logic       ack_received,
    output logic       nak_received,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [3:0]    LAST_SLOT    = 4'(FRAME_BYTES);
    localparam logic [3:0]    CHK_SLOT     = 4'(CHECKSUM);

    state_e        state_r, state_s;
    logic [3:0]    count_r, count_s;
    logic [7:0]    xor_r, xor_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [7:0]    shadow_r [FRAME_BYTES];
    logic [7:0]    field_r  [PAYLOAD_BYTES];
    logic          store_en_s;
    logic [7:0]    store_data_s;
    logic [7:0]    esc_dec_s;
    logic          load_s;
    logic          pv_s, ce_s, fe_s, ack_s, nak_s;
    logic          pv_r, ce_r, fe_r, ack_r, nak_r, busy_r;

    // Next-state, shadow write, checksum accumulation and status pulse decode
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        xor_s        = xor_r;
        timer_s      = timer_r;
        store_en_s   = 1'b0;
        store_data_s = 8'h00;
        load_s       = 1'b0;
        pv_s         = 1'b0;
        ce_s         = 1'b0;
        fe_s         = 1'b0;
        ack_s        = 1'b0;
        nak_s        = 1'b0;
        esc_dec_s    = rx_data - ESC_OFFSET;
        case (state_r)
            ST_IDLE: begin
                timer_s = '0;
                if (rx_valid) begin
                    if (rx_data == STX) begin
                        state_s = ST_BODY;
                        count_s = 4'd0;
                        xor_s   = 8'h00;
                    end else if (rx_data == ACK) begin
                        ack_s = 1'b1;
                    end else if (rx_data == NAK) begin
                        nak_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BODY, ST_ESCAPED: begin
                if (rx_valid) begin
                    timer_s = '0;
                    if (state_r == ST_ESCAPED) begin
                        if (is_reserved_byte(esc_dec_s)) begin
                            store_en_s   = 1'b1;
                            store_data_s = esc_dec_s;
                            count_s      = count_r + 4'd1;
                            xor_s        = (count_r < CHK_SLOT) ? (xor_r ^ esc_dec_s) : xor_r;
                            state_s      = ST_BODY;
                        end else begin
                            fe_s    = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else if (rx_data == ESC) begin
                        // An escape with every slot filled can never complete a valid frame
                        if (count_r == LAST_SLOT) begin
                            fe_s    = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_ESCAPED;
                        end
                    end else if (rx_data == STX) begin
                        fe_s    = 1'b1;
                        count_s = 4'd0;
                        xor_s   = 8'h00;
                    end else if (rx_data == ETX) begin
                        state_s = ST_IDLE;
                        if (count_r != LAST_SLOT) begin
                            fe_s = 1'b1;
                        end else if (xor_r == shadow_r[CHECKSUM]) begin
                            load_s = 1'b1;
                            pv_s   = 1'b1;
                        end else begin
                            ce_s = 1'b1;
                        end
                    end else if ((rx_data == ACK) || (rx_data == NAK) || (count_r == LAST_SLOT)) begin
                        fe_s    = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        store_en_s   = 1'b1;
                        store_data_s = rx_data;
                        count_s      = count_r + 4'd1;
                        xor_s        = (count_r < CHK_SLOT) ? (xor_r ^ rx_data) : xor_r;
                    end
                end else if (TIMEOUT_CYCLES == 32'd0) begin
                    timer_s = '0;
                end else if (timer_r == TIMEOUT_LAST) begin
                    fe_s    = 1'b1;
                    state_s = ST_IDLE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, shadow file, published fields and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            xor_r   <= 8'h00;
            timer_r <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) shadow_r[i] <= 8'h00;
            for (int i = 0; i < PAYLOAD_BYTES; i++) field_r[i] <= 8'h00;
            pv_r    <= 1'b0;
            ce_r    <= 1'b0;
            fe_r    <= 1'b0;
            ack_r   <= 1'b0;
            nak_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            xor_r   <= xor_s;
            timer_r <= timer_s;
            if (store_en_s) begin
                shadow_r[count_r] <= store_data_s;
            end
            if (load_s) begin
                for (int i = 0; i < PAYLOAD_BYTES; i++) field_r[i] <= shadow_r[i];
            end
            pv_r    <= pv_s;
            ce_r    <= ce_s;
            fe_r    <= fe_s;
            ack_r   <= ack_s;
            nak_r   <= nak_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign command        = field_r[COMMAND];
    assign address_0      = field_r[ADDRESS_0];
    assign address_1      = field_r[ADDRESS_1];
    assign address_2      = field_r[ADDRESS_2];
    assign address_3      = field_r[ADDRESS_3];
    assign address_4      = field_r[ADDRESS_4];
    assign address_5      = field_r[ADDRESS_5];
    assign sv_0           = field_r[SV_0];
    assign sv_1           = field_r[SV_1];
    assign data_0         = field_r[DATA_0];
    assign data_1         = field_r[DATA_1];
    assign data_2         = field_r[DATA_2];
    assign data_3         = field_r[DATA_3];
    assign packet_valid   = pv_r;
    assign checksum_error = ce_r;
    assign framing_error  = fe_r;
    assign ack_received   = ack_r;
    assign nak_received   = nak_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_soundweb_decoder.sv
// Scoreboard bench for soundweb_decoder: expected pulses and field snapshots are
// queued as frames are driven and matched whenever the decoder emits a pulse.
module tb_soundweb_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
    logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
    logic       packet_valid, checksum_error, framing_error, ack_received, nak_received, busy;

    soundweb_decoder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .command(command),
        .address_0(address_0), .address_1(address_1), .address_2(address_2),
        .address_3(address_3), .address_4(address_4), .address_5(address_5),
        .sv_0(sv_0), .sv_1(sv_1),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .packet_valid(packet_valid), .checksum_error(checksum_error),
        .framing_error(framing_error), .ack_received(ack_received),
        .nak_received(nak_received), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] K_PV  = 5'b10000;
    localparam logic [4:0] K_CE  = 5'b01000;
    localparam logic [4:0] K_FE  = 5'b00100;
    localparam logic [4:0] K_ACK = 5'b00010;
    localparam logic [4:0] K_NAK = 5'b00001;

    typedef struct {
        logic [4:0]   code;
        logic         busy;
        logic [103:0] fields;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_fields [13];
    logic [7:0] good_q[$] = '{8'h02, 8'h88, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'hED, 8'h03};

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [103:0] dut_fields();
        return {command, address_0, address_1, address_2, address_3, address_4, address_5,
                sv_0, sv_1, data_0, data_1, data_2, data_3};
    endfunction

    function automatic logic [103:0] model_fields();
        logic [103:0] v;
        v = '0;
        for (int i = 0; i < 13; i++) v = {v[95:0], exp_fields[i]};
        return v;
    endfunction

    function automatic logic [109:0] all_outputs();
        return {dut_fields(), packet_valid, checksum_error, framing_error,
                ack_received, nak_received, busy};
    endfunction

    function automatic logic tb_reserved(input logic [7:0] b);
        return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) || (b == 8'h15) || (b == 8'h1B);
    endfunction

    task automatic expect_pulse(input logic [4:0] code, input logic busy_exp);
        exp_t e;
        e.code   = code;
        e.busy   = busy_exp;
        e.fields = model_fields();
        sb.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 13; i++) exp_fields[i] = 8'h00;
    endtask

    task automatic model_good();
        model_clear();
        exp_fields[0]  = 8'h88;
        exp_fields[3]  = 8'h01;
        exp_fields[12] = 8'h64;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_random_packet();
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        q.push_back(8'h02);
        for (int i = 0; i < 14; i++) begin
            if (i < 13) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 4))
                        0:       b = 8'h02;
                        1:       b = 8'h03;
                        2:       b = 8'h06;
                        3:       b = 8'h15;
                        default: b = 8'h1B;
                    endcase
                end else begin
                    b = 8'($urandom_range(0, 255));
                end
                exp_fields[i] = b;
                x = x ^ b;
            end else begin
                b = x;
            end
            if (tb_reserved(b)) begin
                q.push_back(8'h1B);
                q.push_back(b + 8'h80);
            end else begin
                q.push_back(b);
            end
        end
        q.push_back(8'h03);
        expect_pulse(K_PV, 1'b0);
        send_list(q);
    endtask

    // Scoreboard consumer: every status pulse must match the oldest expectation
    always @(negedge clk) begin
        logic [4:0] code;
        exp_t       e;
        if (!rst) begin
            code = {packet_valid, checksum_error, framing_error, ack_received, nak_received};
            if (code != 5'd0) begin
                if (sb.size() == 0) begin
                    check_value("unexpected_pulse", 128'(code), 128'd0);
                end else begin
                    e = sb.pop_front();
                    check_value("pulse_kind", 128'(code), 128'(e.code));
                    check_value("busy_at_pulse", 128'(busy), 128'(e.busy));
                    check_value("fields", 128'(dut_fields()), 128'(e.fields));
                end
            end
        end
    end

    initial begin
        int lat;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs", 128'(all_outputs()), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        model_good();
        expect_pulse(K_PV, 1'b0);
        send_list(good_q);
        idle(2);

        exp_fields[12] = 8'h03;
        expect_pulse(K_PV, 1'b0);
        send_list('{8'h02, 8'h88, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h1B, 8'h83, 8'h8A, 8'h03});
        idle(2);

        expect_pulse(K_CE, 1'b0);
        send_list('{8'h02, 8'h88, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h64, 8'hEE, 8'h03});
        idle(2);

        expect_pulse(K_FE, 1'b0);
        send_list('{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h03});
        expect_pulse(K_FE, 1'b0);
        send_list('{8'h02, 8'h11, 8'h1B, 8'h41});
        expect_pulse(K_FE, 1'b0);
        send_list('{8'h02, 8'h88, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h64, 8'hED, 8'h77});
        idle(2);

        expect_pulse(K_ACK, 1'b0);
        expect_pulse(K_NAK, 1'b0);
        send_list('{8'h06, 8'h15});
        idle(2);

        expect_pulse(K_FE, 1'b1);
        model_good();
        expect_pulse(K_PV, 1'b0);
        send_list('{8'h02, 8'h11, 8'h22});
        send_list(good_q);

        for (int n = 0; n < 4; n++) send_random_packet();
        idle(2);

        expect_pulse(K_FE, 1'b0);
        send_list('{8'h02, 8'h88});
        check_value("busy_in_frame", 128'(busy), 128'd1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (framing_error) begin
                lat = n;
                break;
            end
        end
        check_value("timeout_latency", 128'(lat), 128'd8);
        check_value("busy_after_timeout", 128'(busy), 128'd0);
        idle(2);

        send_list('{8'h02, 8'h88, 8'h00});
        #2;
        rst = 1'b1;
        #1;
        check_value("async_reset", 128'(all_outputs()), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        model_good();
        expect_pulse(K_PV, 1'b0);
        send_list(good_q);
        idle(5);

        check_value("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
